// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution controller: opcodes, legal range,
// FSM encoding, flag bit positions and small opcode-classification helpers.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b001001;
    localparam logic [5:0] OP_SUB = 6'b001010;
    localparam logic [5:0] OP_AND = 6'b001011;
    localparam logic [5:0] OP_OR  = 6'b001100;
    localparam logic [5:0] OP_XOR = 6'b001101;
    localparam logic [5:0] OP_MOV = 6'b001111;
    localparam logic [5:0] OP_NOT = 6'b010110;
    localparam logic [5:0] OP_CMP = 6'b010111;
    localparam logic [5:0] OP_INC = 6'b011001;
    localparam logic [5:0] OP_DEC = 6'b011010;

    localparam logic [5:0] OP_MIN = 6'b001001;
    localparam logic [5:0] OP_MAX = 6'b011010;

    localparam int REG_AW = 3;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WB     = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op >= OP_MIN) && (op <= OP_MAX);
    endfunction

    // Single-operand opcodes present a clean zero on operand B.
    function automatic logic op_zero_b(input logic [5:0] op);
        return (op == OP_MOV) || (op == OP_NOT) || (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction channel and ALU channel of the execution controller.
// master = environment side (instruction source + ALU), slave = controller.
interface alu_exec_ctrl_if #(
    parameter int DATA_W = 16
);
    import alu_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [5:0]        instr_opcode;
    logic [REG_AW-1:0] instr_rd;
    logic [REG_AW-1:0] instr_rs;
    logic [REG_AW-1:0] instr_rt;
    logic              instr_use_imm;
    logic [15:0]       instr_imm;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [5:0]        alu_opcode;
    logic              alu_op;
    logic [DATA_W:0]   alu_result;
    logic              alu_zf;
    logic              alu_cf;
    logic              alu_nf;
    logic              alu_of;

    modport master (
        output instr_valid, instr_opcode, instr_rd, instr_rs, instr_rt,
               instr_use_imm, instr_imm,
        input  instr_ready,
        input  alu_a, alu_b, alu_opcode, alu_op,
        output alu_result, alu_zf, alu_cf, alu_nf, alu_of
    );

    modport slave (
        input  instr_valid, instr_opcode, instr_rd, instr_rs, instr_rt,
               instr_use_imm, instr_imm,
        output instr_ready,
        output alu_a, alu_b, alu_opcode, alu_op,
        input  alu_result, alu_zf, alu_cf, alu_nf, alu_of
    );

endinterface

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational operand reads, a debug read,
// one synchronous write port and a synchronous active-low clear.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_rd [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DATA_W-1:0] reg_q;
            logic [DATA_W-1:0] reg_d;

            always_comb begin
                reg_d = reg_q;
                if (we && (waddr == REG_AW'(gi))) begin
                    reg_d = wdata;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    reg_q <= '0;
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_rd[gi] = reg_q;
        end
    endgenerate

    // Reads see the pre-write contents, so rd == rs/rt uses the old value.
    assign rdata_a  = regs_rd[raddr_a];
    assign rdata_b  = regs_rd[raddr_b];
    assign dbg_data = regs_rd[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execution controller: accepts one instruction, drives the
// external ALU for two cycles, then writes the result and flags back.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    alu_exec_ctrl_if.slave    bus,
    output logic [3:0]        flags,
    output logic              done,
    output logic              err,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [REG_AW-1:0] rs_q, rs_d;
    logic [REG_AW-1:0] rt_q, rt_d;
    logic              use_imm_q, use_imm_d;
    logic [15:0]       imm_q, imm_d;
    logic [3:0]        flags_q, flags_d;

    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              wb_we;
    logic              issuing;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_we),
        .waddr    (rd_q),
        .wdata    (bus.alu_result[DATA_W-1:0]),
        .raddr_a  (rs_q),
        .rdata_a  (rdata_a),
        .raddr_b  (rt_q),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            use_imm_q <= 1'b0;
            imm_q     <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            use_imm_q <= use_imm_d;
            imm_q     <= imm_d;
            flags_q   <= flags_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        use_imm_d = use_imm_q;
        imm_d     = imm_q;
        flags_d   = flags_q;
        wb_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    op_d      = bus.instr_opcode;
                    rd_d      = bus.instr_rd;
                    rs_d      = bus.instr_rs;
                    rt_d      = bus.instr_rt;
                    use_imm_d = bus.instr_use_imm;
                    imm_d     = bus.instr_imm;
                    state_d   = op_is_legal(bus.instr_opcode) ? ST_ISSUE : ST_ERR;
                end
            end
            ST_ISSUE:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_WB;
            ST_WB: begin
                wb_we   = (op_q != OP_CMP);
                flags_d = {bus.alu_zf, bus.alu_cf, bus.alu_nf, bus.alu_of};
                state_d = ST_IDLE;
            end
            ST_ERR:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ALU drive is zero whenever no operation is in flight.
    always_comb begin
        issuing         = (state_q == ST_ISSUE) || (state_q == ST_SETTLE);
        bus.instr_ready = (state_q == ST_IDLE);
        bus.alu_op      = issuing;
        bus.alu_opcode  = '0;
        bus.alu_a       = '0;
        bus.alu_b       = '0;
        if (issuing) begin
            bus.alu_opcode = op_q;
            bus.alu_a      = rdata_a;
            if (!op_zero_b(op_q)) begin
                bus.alu_b = use_imm_q ? DATA_W'(imm_q) : rdata_b;
            end
        end
    end

    assign flags = flags_q;
    assign done  = (state_q == ST_WB);
    assign err   = (state_q == ST_ERR);

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a registered ALU model answers the DUT, and a
// transaction-level model predicts every output on every cycle.
module tb_alu_exec_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  flags;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #5 clk = ~clk;

    alu_exec_ctrl_if #(.DATA_W(16)) bus();

    alu_exec_ctrl #(.DATA_W(16), .NREGS(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flags    (flags),
        .done     (done),
        .err      (err),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // ALU behaviour used both by the bench ALU and the reference model.
    function automatic logic [16:0] alu_fn(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:         return {1'b0, a} + {1'b0, b};
            OP_SUB, OP_CMP: return {1'b0, a} - {1'b0, b};
            OP_AND:         return {1'b0, a & b};
            OP_OR:          return {1'b0, a | b};
            OP_XOR:         return {1'b0, a ^ b};
            OP_MOV:         return {1'b0, a};
            OP_NOT:         return {1'b0, ~a};
            OP_INC:         return {1'b0, a} + 17'd1;
            OP_DEC:         return {1'b0, a} - 17'd1;
            default:        return {1'b0, a ^ {b[7:0], b[15:8]}};
        endcase
    endfunction

    function automatic logic [3:0] flag_fn(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] r;
        logic        o;
        r = alu_fn(op, a, b);
        o = 1'b0;
        if (op == OP_ADD) o = (a[15] == b[15]) && (r[15] != a[15]);
        if (op == OP_SUB || op == OP_CMP) o = (a[15] != b[15]) && (r[15] != a[15]);
        return {r[15:0] == 16'h0000, r[16], r[15], o};
    endfunction

    logic [16:0] alu_res_r = '0;
    logic [3:0]  alu_flg_r = '0;
    always @(posedge clk) begin
        if (bus.alu_op) begin
            alu_res_r <= alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
            alu_flg_r <= flag_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
        end
    end
    assign bus.alu_result = alu_res_r;
    assign bus.alu_zf     = alu_flg_r[3];
    assign bus.alu_cf     = alu_flg_r[2];
    assign bus.alu_nf     = alu_flg_r[1];
    assign bus.alu_of     = alu_flg_r[0];

    // Reference model: architectural state plus the in-flight instruction.
    logic [15:0] m_reg [8];
    logic [3:0]  m_flags;
    bit          m_busy, m_legal, known;
    int          m_cyc, m_acc;
    logic [5:0]  m_op;
    logic [2:0]  m_rd, m_rs;
    logic [15:0] m_b;
    logic [16:0] m_res;
    logic [3:0]  m_fl;
    int          checks = 0;
    int          errors = 0;

    task automatic model_edge(input logic rstn, input logic v, input logic [5:0] op,
                              input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                              input logic ui, input logic [15:0] imm);
        int d;
        bit zb;
        if (!rstn) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
            m_flags = 4'b0000;
            m_busy  = 0;
            known   = 1;
        end else if (m_busy) begin
            d = m_cyc - m_acc;
            if (m_legal && d == 3) begin
                if (m_op != 6'b010111) m_reg[m_rd] = m_res[15:0];
                m_flags = m_fl;
                m_busy  = 0;
            end else if (!m_legal && d == 1) begin
                m_busy = 0;
            end
        end else if (v && known) begin
            zb      = (op == 6'b001111) || (op == 6'b010110) || (op == 6'b011001) || (op == 6'b011010);
            m_op    = op;
            m_rd    = rd;
            m_rs    = rs;
            m_legal = (op >= 6'd9) && (op <= 6'd26);
            m_b     = zb ? 16'h0000 : (ui ? imm : m_reg[rt]);
            m_res   = alu_fn(op, m_reg[rs], m_b);
            m_fl    = flag_fn(op, m_reg[rs], m_b);
            m_busy  = 1;
            m_acc   = m_cyc;
        end
        m_cyc++;
    endtask

    task automatic compare();
        int          d;
        logic        e_op, e_done, e_err, e_rdy;
        logic [15:0] e_a, e_b;
        logic [5:0]  e_opc;
        if (!known) return;
        d      = m_cyc - m_acc;
        e_rdy  = !m_busy;
        e_op   = m_busy && m_legal && (d == 1 || d == 2);
        e_done = m_busy && m_legal && (d == 3);
        e_err  = m_busy && !m_legal && (d == 1);
        e_a    = e_op ? m_reg[m_rs] : 16'h0000;
        e_b    = e_op ? m_b : 16'h0000;
        e_opc  = e_op ? m_op : 6'd0;
        checks++;
        if (bus.instr_ready !== e_rdy || bus.alu_op !== e_op || bus.alu_a !== e_a || bus.alu_b !== e_b ||
            bus.alu_opcode !== e_opc || done !== e_done || err !== e_err || flags !== m_flags ||
            dbg_data !== m_reg[dbg_addr]) begin
            errors++;
            $display("FAIL cycle%0d rdy/op/a/b/opc/done/err/flags/dbg got %b %b %h %h %h %b %b %b %h want %b %b %h %h %h %b %b %b %h",
                     m_cyc, bus.instr_ready, bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_opcode, done, err, flags, dbg_data,
                     e_rdy, e_op, e_a, e_b, e_opc, e_done, e_err, m_flags, m_reg[dbg_addr]);
        end
    endtask

    task automatic cycle(input logic rstn, input logic v, input logic [5:0] op,
                         input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                         input logic ui, input logic [15:0] imm);
        rst                = rstn;
        bus.instr_valid    = v;
        bus.instr_opcode   = op;
        bus.instr_rd       = rd;
        bus.instr_rs       = rs;
        bus.instr_rt       = rt;
        bus.instr_use_imm  = ui;
        bus.instr_imm      = imm;
        dbg_addr           = 3'($urandom_range(0, 7));
        @(posedge clk);
        model_edge(rstn, v, op, rd, rs, rt, ui, imm);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
    endtask

    // One instruction from an idle block; checks the cycle at which done/err shows.
    task automatic issue(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic ui, input logic [15:0] imm,
                         input int want_k, input string name);
        int k;
        k = 0;
        cycle(1'b1, 1'b1, op, rd, rs, rt, ui, imm);
        if (done || err) k = 1;
        for (int i = 2; i <= 8 && k == 0; i++) begin
            idle();
            if (done || err) k = i;
        end
        checks++;
        if (k != want_k) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, k, want_k);
        end
        idle();
    endtask

    task automatic expect_reg(input logic [2:0] a, input logic [15:0] val, input string name);
        dbg_addr = a;
        #1;
        checks++;
        if (dbg_data !== val || m_reg[a] !== val) begin
            errors++;
            $display("FAIL %s R%0d got dut %h model %h want %h", name, a, dbg_data, m_reg[a], val);
        end
    endtask

    task automatic expect_flags(input logic [3:0] val, input string name);
        checks++;
        if (flags !== val || m_flags !== val) begin
            errors++;
            $display("FAIL %s flags got dut %b model %b want %b", name, flags, m_flags, val);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dseen;
        logic [5:0] rop;
        m_busy = 0; known = 0; m_cyc = 0; m_acc = 0; m_flags = 4'b0000;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;

        // Reset held two cycles with an instruction offered.
        cycle(1'b0, 1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234);
        cycle(1'b0, 1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234);
        idle();
        checks++;
        if (bus.instr_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got rdy %b done %b want 1 0", bus.instr_ready, done);
        end
        for (int i = 0; i < 8; i++) expect_reg(3'(i), 16'h0000, "reset_regs");
        expect_flags(4'b0000, "reset_flags");

        // ADD register-register.
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0011, 3, "pre_r1");
        issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0002, 3, "pre_r2");
        issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'hBEEF, 3, "add");
        expect_reg(3'd3, 16'h0013, "add_r3");
        expect_flags(4'b0000, "add_flags");

        // Carry out and zero; rd == rs reads the old value.
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 3, "pre_ffff");
        issue(OP_ADD, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0001, 3, "carry");
        expect_reg(3'd4, 16'h0000, "carry_r4");
        expect_flags(4'b1100, "carry_flags");
        issue(OP_INC, 3'd1, 3'd1, 3'd7, 1'b1, 16'h5555, 3, "inc_self");
        expect_reg(3'd1, 16'h0000, "inc_self_r1");
        expect_flags(4'b1100, "inc_flags");

        // CMP writes only flags.
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 3, "pre_5");
        issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0009, 3, "pre_9");
        issue(OP_CMP, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0000, 3, "cmp");
        expect_reg(3'd1, 16'h0005, "cmp_r1");
        expect_flags(4'b0110, "cmp_flags");

        // Illegal opcode.
        issue(6'b000000, 3'd1, 3'd2, 3'd2, 1'b0, 16'h0000, 1, "illegal");
        expect_reg(3'd1, 16'h0005, "illegal_r1");
        expect_flags(4'b0110, "illegal_flags");

        // Reset while the ADD into R5 is in SETTLE.
        dseen = 0;
        cycle(1'b1, 1'b1, OP_ADD, 3'd5, 3'd1, 3'd2, 1'b0, 16'h0000);
        dseen += int'(done);
        idle();
        dseen += int'(done);
        cycle(1'b0, 1'b0, 6'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        dseen += int'(done);
        idle();
        dseen += int'(done);
        checks++;
        if (dseen != 0 || bus.instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort done pulses %0d rdy %b want 0 1", dseen, bus.instr_ready);
        end
        expect_reg(3'd5, 16'h0000, "abort_r5");
        expect_flags(4'b0000, "abort_flags");

        // Randomized traffic, including offers while busy and occasional resets.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 9) < 8) rop = 6'($urandom_range(9, 26));
            else                          rop = 6'($urandom_range(0, 63));
            cycle(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), rop,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
